// File: rtl/sr_uart_tx_mmio.sv
// sr_uart_tx_mmio: memory-mapped 8N1 UART transmitter on the CPU data port.
//
// A store to DATA queues a byte in the TX FIFO. The serialiser drains the
// FIFO and sends each byte as start, 8 data bits LSB first, optional parity,
// then stop. STATUS and DIV are read back through a combinational,
// size/sign-adjusted load path.
//
// Register map (offset = dmAddr[3:0]):
//   0x0 DATA   (W)     push dmDataW[7:0]; reads 0
//   0x4 STATUS (R/W1C) [0] busy [1] full [2] empty [3] overflow
//                      [4] parity build [15:8] FIFO count;
//                      storing dmDataW[3]=1 clears overflow
//   0x8 DIV    (R/W)   [15:0] clocks per bit, word stores only, 0 acts as 1
//   0xC and unaligned accesses: read 0, stores ignored
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   dmAddr, dmDataW, dmWe        CPU data address, store data, store strobe
//   op_byte, op_half, op_word    one-hot access size
//   dmSign                       sign-extend sub-word loads
//   dmDataR                      load data (0 when sel=0)
//   sel                          address hits this register block
//   uartTx                       serial line, registered, idle high
//
// Build option: define SR_UART_PARITY_EN to add an even-parity bit
// (11-bit frame, STATUS bit4 reads 1).

module sr_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmAddr,
  input  logic [31:0] dmDataW,
  input  logic        dmWe,
  input  logic        op_byte,
  input  logic        op_half,
  input  logic        op_word,
  input  logic        dmSign,
  output logic [31:0] dmDataR,
  output logic        sel,
  output logic        uartTx
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RESET  = 16'(CLK_DIV);

`ifdef SR_UART_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state, stateNext;
  logic [15:0] divReg, bitTimer, bitTimerNext, bitLoad;
  logic [2:0]  bitIdx, bitIdxNext, nextIdx;
  logic [7:0]  shiftReg, shiftNext, headByte;
  logic        txReg, txNext;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic        overflow, fifoFull, fifoEmpty, pop, busy;
  logic        regWrite, pushReq, pushOk, statusWrite, divWrite;
  logic [3:0]  offset;
  logic [31:0] statusWord, regWord, laneWord, loadWord;
  logic        aligned;
  logic        unusedDataHi;

  assign offset       = dmAddr[3:0];
  assign sel          = (dmAddr[31:4] == BASE_ADDR[31:4]);
  assign unusedDataHi = ^dmDataW[31:16];

  // Register writes need a word-aligned offset; only DIV also demands op_word.
  assign regWrite    = sel & dmWe & (offset[1:0] == 2'b00);
  assign pushReq     = regWrite & (offset[3:2] == 2'd0);
  assign statusWrite = regWrite & (offset[3:2] == 2'd1);
  assign divWrite    = regWrite & (offset[3:2] == 2'd2) & op_word;

  assign fifoFull  = (count == FULL_COUNT);
  assign fifoEmpty = (count == {(AW+1){1'b0}});
  // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
  assign pushOk    = pushReq & (~fifoFull | pop);
  assign headByte  = fifoMem[rdPtr];
  assign busy      = (state != IDLE);
  assign uartTx    = txReg;

  // Reload value for the bit timer; a divisor of 0 behaves as 1.
  assign bitLoad = (divReg == 16'd0) ? 16'd0 : divReg - 16'd1;
  assign nextIdx = bitIdx + 3'd1;

  // FIFO storage array: written on every accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= dmDataW[7:0];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the divisor register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= {AW{1'b0}};
      rdPtr    <= {AW{1'b0}};
      count    <= {(AW+1){1'b0}};
      overflow <= 1'b0;
      divReg   <= DIV_RESET;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (pop)    rdPtr <= rdPtr + AW'(1);
      case ({pushOk, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pushReq && !pushOk) begin
        overflow <= 1'b1;
      end else if (statusWrite && dmDataW[3]) begin
        overflow <= 1'b0;
      end
      if (divWrite) divReg <= dmDataW[15:0];
    end
  end

  // Serialiser state register; the line output is registered from txNext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitTimer <= 16'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'h00;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      bitTimer <= bitTimerNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  // Next-state logic: each bit lasts bitLoad+1 clocks; txNext is the level
  // of the bit that starts at the coming edge.
  always_comb begin
    stateNext    = state;
    bitTimerNext = bitTimer - 16'd1;
    bitIdxNext   = bitIdx;
    shiftNext    = shiftReg;
    txNext       = txReg;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        bitTimerNext = bitTimer;
        txNext       = 1'b1;
        if (!fifoEmpty) begin
          pop          = 1'b1;
          shiftNext    = headByte;
          stateNext    = START;
          bitTimerNext = bitLoad;
          txNext       = 1'b0;
        end else begin
          stateNext = IDLE;
        end
      end
      START: begin
        if (bitTimer == 16'd0) begin
          stateNext    = DATA;
          bitIdxNext   = 3'd0;
          bitTimerNext = bitLoad;
          txNext       = shiftReg[0];
        end else begin
          stateNext = START;
        end
      end
      DATA: begin
        if (bitTimer == 16'd0) begin
          bitTimerNext = bitLoad;
          if (bitIdx == 3'd7) begin
`ifdef SR_UART_PARITY_EN
            stateNext = PARITY;
            txNext    = evenParity(shiftReg);
`else
            stateNext = STOP;
            txNext    = 1'b1;
`endif
          end else begin
            bitIdxNext = nextIdx;
            txNext     = shiftReg[nextIdx];
          end
        end else begin
          stateNext = DATA;
        end
      end
`ifdef SR_UART_PARITY_EN
      PARITY: begin
        if (bitTimer == 16'd0) begin
          stateNext    = STOP;
          bitTimerNext = bitLoad;
          txNext       = 1'b1;
        end else begin
          stateNext = PARITY;
        end
      end
`endif
      STOP: begin
        if (bitTimer == 16'd0) begin
          if (!fifoEmpty) begin
            // Chain straight into the next start bit with no idle gap.
            pop          = 1'b1;
            shiftNext    = headByte;
            stateNext    = START;
            bitTimerNext = bitLoad;
            txNext       = 1'b0;
          end else begin
            stateNext    = IDLE;
            bitTimerNext = 16'd0;
            txNext       = 1'b1;
          end
        end else begin
          stateNext = STOP;
        end
      end
      default: begin
        stateNext    = IDLE;
        bitTimerNext = 16'd0;
        txNext       = 1'b1;
      end
    endcase
  end

  assign statusWord = {16'h0000, 8'(count), 3'b000, PARITY_FLAG,
                       overflow, fifoEmpty, fifoFull, busy};

  // Load path: pick the register, shift the addressed lane down, size/sign it.
  always_comb begin
    case (offset[3:2])
      2'd1:    regWord = statusWord;
      2'd2:    regWord = {16'h0000, divReg};
      default: regWord = 32'h0000_0000;
    endcase
    if (op_word) begin
      aligned = (offset[1:0] == 2'b00);
    end else if (op_half) begin
      aligned = ~offset[0];
    end else begin
      aligned = 1'b1;
    end
    laneWord = regWord >> {offset[1:0], 3'b000};
    if (op_byte) begin
      loadWord = {{24{dmSign & laneWord[7]}}, laneWord[7:0]};
    end else if (op_half) begin
      loadWord = {{16{dmSign & laneWord[15]}}, laneWord[15:0]};
    end else begin
      loadWord = laneWord;
    end
    if (sel && aligned) begin
      dmDataR = loadWord;
    end else begin
      dmDataR = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_sr_uart_tx_mmio.sv
// Bench for sr_uart_tx_mmio: directed stimulus, a queue-based line model that
// predicts uartTx every cycle, and hand-computed literal expectations.
// Honours SR_UART_PARITY_EN when defined.

module tb_sr_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          DEPTH = 8;
`ifdef SR_UART_PARITY_EN
  localparam int          NB    = 11;
  localparam logic [31:0] PB    = 32'h0000_0010;
  localparam logic [10:0] FR_A5 = 11'h54A;
  localparam logic [10:0] FR_3C = 11'h478;
`else
  localparam int          NB    = 10;
  localparam logic [31:0] PB    = 32'h0000_0000;
  localparam logic [10:0] FR_A5 = 11'h34A;
  localparam logic [10:0] FR_3C = 11'h278;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmAddr = 32'h0;
  logic [31:0] dmDataW = 32'h0;
  logic        dmWe = 1'b0;
  logic        op_byte = 1'b0;
  logic        op_half = 1'b0;
  logic        op_word = 1'b1;
  logic        dmSign = 1'b0;
  logic [31:0] dmDataR;
  logic        sel;
  logic        uartTx;

  int checks = 0;
  int errors = 0;

  sr_uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .dmAddr(dmAddr), .dmDataW(dmDataW),
    .dmWe(dmWe), .op_byte(op_byte), .op_half(op_half), .op_word(op_word),
    .dmSign(dmSign), .dmDataR(dmDataR), .sel(sel), .uartTx(uartTx)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] fifoQ[$];
  bit         lineQ[$];
  int         mDiv = 16;
  bit         mOvf = 1'b0;
  bit         expTx = 1'b1;
  bit         mBusy = 1'b0;

  // Append one whole frame, each bit repeated for max(DIV,1) clocks.
  task automatic addFrame(input logic [7:0] b);
    int d;
    bit bits[$];
    d = (mDiv == 0) ? 1 : mDiv;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef SR_UART_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[j]) for (int r = 0; r < d; r++) lineQ.push_back(bits[j]);
  endtask

  task automatic modelStep();
    bit v;
    if (!rst_n) begin
      fifoQ.delete(); lineQ.delete();
      mDiv = 16; mOvf = 1'b0; expTx = 1'b1; mBusy = 1'b0;
    end else begin
      // The transmitter takes a new byte once the previous frame is fully out.
      if (lineQ.size() == 0 && fifoQ.size() != 0) addFrame(fifoQ.pop_front());
      if (dmWe && dmAddr == BASE) begin
        if (fifoQ.size() < DEPTH) fifoQ.push_back(dmDataW[7:0]);
        else mOvf = 1'b1;
      end
      if (dmWe && dmAddr == BASE + 32'd4 && dmDataW[3]) mOvf = 1'b0;
      if (dmWe && dmAddr == BASE + 32'd8 && op_word) mDiv = int'(dmDataW[15:0]);
      if (lineQ.size() != 0) begin
        v = lineQ.pop_front(); expTx = v; mBusy = 1'b1;
      end else begin
        expTx = 1'b1; mBusy = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) modelStep();

  function automatic logic [31:0] expStatus();
    logic [7:0] c;
    c = 8'(fifoQ.size());
    return {16'h0, c, 3'b000, PB[4], mOvf, (fifoQ.size() == 0),
            (fifoQ.size() == DEPTH), mBusy};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare the line against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("uartTx_model", 32'(uartTx), 32'(expTx));
  endtask

  task automatic setSize(input int size);
    op_byte = (size == 1);
    op_half = (size == 2);
    op_word = (size == 4);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int size);
    dmAddr = a; dmDataW = d; dmWe = 1'b1; setSize(size);
    tick();
    dmWe = 1'b0;
  endtask

  task automatic chkRd(input string name, input logic [31:0] a, input int size,
                       input bit sgn, input logic [31:0] exp);
    dmWe = 1'b0; dmAddr = a; dmSign = sgn; setSize(size);
    #1;
    chk(name, dmDataR, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #12;
    chk("tx_in_reset", 32'(uartTx), 32'h1);
    rst_n = 1'b1;
    tick();
    chkRd("status_reset", BASE + 32'd4, 4, 1'b0, 32'h4 | PB);
    chkRd("status_reset_model", BASE + 32'd4, 4, 1'b0, expStatus());
    chkRd("div_reset", BASE + 32'd8, 4, 1'b0, 32'd16);

    // Single frame, DIV=4.
    wr(BASE + 32'd8, 32'd4, 4);
    chkRd("div_4", BASE + 32'd8, 4, 1'b0, 32'd4);
    wr(BASE, 32'h0000_00A5, 1);
    chk("tx_at_store_edge", 32'(uartTx), 32'h1);
    for (int i = 0; i < NB * 4; i++) begin
      tick();
      chk("frame_A5", 32'(uartTx), 32'(FR_A5[i / 4]));
      if (i == 5) chkRd("status_busy", BASE + 32'd4, 4, 1'b0, 32'h5 | PB);
    end
    tick();
    chkRd("status_idle_A5", BASE + 32'd4, 4, 1'b0, 32'h4 | PB);

    // Back-to-back frames and overflow, DIV=2.
    wr(BASE + 32'd8, 32'd2, 4);
    wr(BASE, 32'h0000_0000, 1);
    for (int k = 1; k <= 9; k++) wr(BASE, 32'(8'h11 * k), 1);
    chkRd("status_full_ovf", BASE + 32'd4, 4, 1'b0, 32'h80B | PB);
    chkRd("status_model", BASE + 32'd4, 4, 1'b0, expStatus());
    chkRd("count_byte_lane", BASE + 32'd5, 1, 1'b1, 32'h08);
    wr(BASE + 32'd4, 32'h8, 4);
    chkRd("status_ovf_cleared", BASE + 32'd4, 4, 1'b0, 32'h803 | PB);
    repeat (NB * 18 - 10 + 1) tick();
    chkRd("status_after_burst", BASE + 32'd4, 4, 1'b0, 32'h4 | PB);

    // Load sizing, lanes and sign extension through DIV.
    wr(BASE + 32'd8, 32'h0000_0080, 4);
    chkRd("byte_sext", BASE + 32'd8, 1, 1'b1, 32'hFFFF_FF80);
    chkRd("byte_zext", BASE + 32'd8, 1, 1'b0, 32'h0000_0080);
    chkRd("half_sext_pos", BASE + 32'd8, 2, 1'b1, 32'h0000_0080);
    tick();
    wr(BASE + 32'd8, 32'h0000_8000, 4);
    chkRd("byte_lane1_sext", BASE + 32'd9, 1, 1'b1, 32'hFFFF_FF80);
    chkRd("half_sext", BASE + 32'd8, 2, 1'b1, 32'hFFFF_8000);
    chkRd("half_zext", BASE + 32'd8, 2, 1'b0, 32'h0000_8000);
    wr(BASE + 32'd8, 32'h0000_0055, 1);
    chkRd("div_byte_store_ignored", BASE + 32'd8, 4, 1'b0, 32'h0000_8000);
    chkRd("unaligned_word", BASE + 32'd6, 4, 1'b0, 32'h0);
    chkRd("data_reads_zero", BASE, 4, 1'b0, 32'h0);
    tick();
    chkRd("offset_c_zero", BASE + 32'd12, 4, 1'b0, 32'h0);
    chkRd("outside_zero", BASE + 32'd16, 4, 1'b0, 32'h0);
    chk("sel_outside", 32'(sel), 32'h0);
    chkRd("sel_inside_rd", BASE + 32'd4, 4, 1'b0, 32'h4 | PB);
    chk("sel_inside", 32'(sel), 32'h1);

    // DIV=0 behaves as 1 clock per bit.
    wr(BASE + 32'd8, 32'h0, 4);
    wr(BASE, 32'h0000_003C, 1);
    for (int i = 0; i < NB; i++) begin
      tick();
      chk("frame_3C_div0", 32'(uartTx), 32'(FR_3C[i]));
    end
    tick();
    chkRd("status_idle_div0", BASE + 32'd4, 4, 1'b0, 32'h4 | PB);

    // Asynchronous reset in the middle of a data bit.
    wr(BASE + 32'd8, 32'd4, 4);
    wr(BASE, 32'h0000_0000, 1);
    repeat (10) tick();
    chk("tx_mid_data", 32'(uartTx), 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("tx_async_reset", 32'(uartTx), 32'h1);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chkRd("status_after_reset", BASE + 32'd4, 4, 1'b0, 32'h4 | PB);
    chkRd("div_after_reset", BASE + 32'd8, 4, 1'b0, 32'd16);

`ifdef SR_UART_PARITY_EN
    // Parity frame for 0x07: odd number of ones, so parity bit is 1.
    wr(BASE + 32'd8, 32'd4, 4);
    wr(BASE, 32'h0000_0007, 1);
    for (int i = 0; i < 44; i++) begin
      tick();
      if (i == 37) chk("parity_bit_07", 32'(uartTx), 32'h1);
      if (i == 33) chk("data_bit7_07", 32'(uartTx), 32'h0);
    end
    tick();
    chkRd("status_idle_parity", BASE + 32'd4, 4, 1'b0, 32'h14);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
